hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V integer/float pipeline.
- Tracks in-flight destination registers from EX through the last forwarding stage.
- Produces per-operand bypass selects for the instruction in EX, plus load-use stall and bubble controls for IF/ID and the ID→EX register.
- Replaces the fixed two-stage combinational forwarding unit. Adds register-class awareness (int/float), configurable pipeline depth, load-use stalls and flush handling.

Parameters:
- REG_AW, 5, register address width.
- FWD_DEPTH, 2, number of stages after EX that can bypass (1 = MEM, 2 = WB, ...); legal range 1..4.
- LOAD_STALL, 1, stall cycles needed after a load before its data can be bypassed; legal range 0..FWD_DEPTH-1.
- SEL_W, $clog2(FWD_DEPTH+1), width of forward selects.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a live instruction
- id_rs1, id_rs2  in  REG_AW  source addresses in ID
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rs1_fp, id_rs2_fp  in  1  source is a float register
- id_rd  in  REG_AW  destination address in ID
- id_rd_we  in  1  ID instruction writes a register
- id_rd_fp  in  1  destination is a float register
- id_is_load  in  1  ID instruction is a load
- flush  in  1  branch taken in EX; squash the ID instruction
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  load invalid entry into ID→EX
- fwd_a_sel, fwd_b_sel  out  SEL_W  EX operand select: 0 = register file, k = result from stage EX+k
- perf_stall_cnt, perf_fwd_cnt  out  32  performance counters (optional feature)

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Tracking array: entries pos[0..FWD_DEPTH], where pos[0] = EX. Each entry holds valid, rd, we, fp, load, rs1, rs2, rs1_used, rs2_used, rs1_fp, rs2_fp.
- Shift: every cycle, pos[i+1] <= pos[i].
- Load of pos[0]: pos[0] <= ID fields, with valid = id_valid & ~stall & ~flush. A stall or flush therefore inserts an invalid entry (bubble).
- Reset: all entries invalid, so stall=0, bubble=0, fwd_*_sel=0 from the first cycle after reset; counters = 0. Reset dominates all other inputs.
- Matching: a source matches pos[k] when pos[k].valid, pos[k].we, rd equal, and fp class equal. An int source with address 0 never matches; float f0 does match.
- Forward select:
  - Combinational from pos[0] sources against pos[1..FWD_DEPTH].
  - Youngest match (lowest k) wins; no match gives 0.
  - An unused source (rsX_used=0) gives 0.
  - An invalid pos[0] gives 0.
- Load-use stall:
  - stall = id_valid & ~flush & (some used ID source matches pos[j] with pos[j].load, for j in 0..LOAD_STALL-1).
  - bubble = stall | flush.
  - LOAD_STALL=0 ties stall to 0.
  - A dependent instruction stalls exactly LOAD_STALL - j cycles, where j is the load's current position.
- Flush precedence: flush overrides stall in the same cycle (stall=0, bubble=1).
- Register files are write-through, so no bypass beyond the last tracked stage.
- No state machine beyond the shift array. Latency from ID to EX select is 1 cycle.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - perf_stall_cnt increments each cycle stall=1.
  - perf_fwd_cnt increments each cycle either fwd select is non-zero (+1 per cycle, not per operand).
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: both outputs are constant 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - the FWD_NONE = 0 constant;
  - the tracked-entry struct/field layout (valid, rd, we, fp, load, sources);
  - the REG_AW default.
- One sub-module, hazard_match: combinational comparator of one source against one entry (address, class, x0 rule). It is instantiated per operand per stage.

Test Plan:
- add x5 (ID) followed by add x6,x5,x1 → next cycle in EX: fwd_a_sel=1, fwd_b_sel=0; with one unrelated instruction between them, fwd_a_sel=2 (FWD_DEPTH=2).
- lw x7 then add x8,x7,x7 with LOAD_STALL=1 → stall=1 and bubble=1 for exactly 1 cycle; then in EX fwd_a_sel=fwd_b_sel=2.
- Write to x0, then read x0 → sel=0. fadd to f0, then read f0 → sel=1. Int x3 written, then float f3 read → sel=0.
- Two writers to x9 in MEM and WB, reader in EX → sel=1 (youngest wins).
- flush asserted in the same cycle as a load-use stall condition → stall=0, bubble=1; the following cycle has pos[0] invalid and sel=0.
- rst asserted mid-stream with three valid entries → next cycle all sels 0, stall 0. With HAZARD_PERF_CNT_EN, after 3 stall cycles perf_stall_cnt=3, and after rst it reads 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Holds the tracked-entry layout, the "no forward" select value and the
// default register address width used by hazard_forward_unit.
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;
  // Entry address fields are sized to the largest supported REG_AW so one
  // layout serves every configuration; narrower addresses are zero-extended.
  localparam int REG_AW_MAX     = 8;
  localparam int FWD_NONE       = 0;

  typedef logic [REG_AW_MAX-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      we;
    logic      fp;
    logic      load;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rs1_used;
    logic      rs2_used;
    logic      rs1_fp;
    logic      rs2_fp;
  } hz_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one source operand against one tracked pipeline entry.
// Latency: purely combinational. Backpressure: none.
// Ports: src/src_used/src_fp describe the operand; ent_* describe the writer;
// hit is high when the entry will produce the value the operand reads.
module hazard_match
  import hazard_pkg::*;
(
  input  reg_addr_t src,
  input  logic      src_used,
  input  logic      src_fp,
  input  logic      ent_valid,
  input  logic      ent_we,
  input  reg_addr_t ent_rd,
  input  logic      ent_fp,
  output logic      hit
);

  // x0 is hardwired zero so it never has a producer; f0 is a real register.
  logic not_x0;
  assign not_x0 = src_fp | (src != '0);

  assign hit = src_used & ent_valid & ent_we & (ent_rd == src)
             & (ent_fp == src_fp) & not_x0;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: tracks destinations from EX through the
// last bypass stage, drives EX operand bypass selects and load-use stalls.
// Latency: ID fields reach the EX select logic 1 cycle later; stall/bubble and
// selects are combinational from the tracking array and the ID inputs.
// Backpressure: stall holds PC and IF/ID; bubble loads an invalid entry into EX.
// Ports: clk/rst (sync, active-high); id_* describe the instruction in ID;
// flush squashes ID; fwd_a_sel/fwd_b_sel: 0 = regfile, k = stage EX+k.
// Optional macro HAZARD_PERF_CNT_EN builds the perf_stall_cnt/perf_fwd_cnt
// saturating counters; without it both outputs are tied to zero.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STALL = 1,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_rs1_fp,
  input  logic              id_rs2_fp,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_rd_fp,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt
);

  // pos[0] is EX, pos[k] is EX+k.
  hz_entry_t pos [0:FWD_DEPTH];
  hz_entry_t id_ent;
  logic      stall_int;

  reg_addr_t id_rs1_x, id_rs2_x;
  assign id_rs1_x = REG_AW_MAX'(id_rs1);
  assign id_rs2_x = REG_AW_MAX'(id_rs2);

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = id_valid & ~stall_int & ~flush;
    id_ent.rd       = REG_AW_MAX'(id_rd);
    id_ent.we       = id_rd_we;
    id_ent.fp       = id_rd_fp;
    id_ent.load     = id_is_load;
    id_ent.rs1      = id_rs1_x;
    id_ent.rs2      = id_rs2_x;
    id_ent.rs1_used = id_rs1_used;
    id_ent.rs2_used = id_rs2_used;
    id_ent.rs1_fp   = id_rs1_fp;
    id_ent.rs2_fp   = id_rs2_fp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= FWD_DEPTH; i++) pos[i] <= '0;
    end else begin
      pos[0] <= id_ent;
      for (int i = 1; i <= FWD_DEPTH; i++) pos[i] <= pos[i-1];
    end
  end

  // Forwarding: EX operands against every later stage.
  logic [FWD_DEPTH:1] fa_hit, fb_hit;

  for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_fwd
    hazard_match u_match_a (
      .src(pos[0].rs1), .src_used(pos[0].rs1_used & pos[0].valid), .src_fp(pos[0].rs1_fp),
      .ent_valid(pos[k].valid), .ent_we(pos[k].we), .ent_rd(pos[k].rd), .ent_fp(pos[k].fp),
      .hit(fa_hit[k])
    );
    hazard_match u_match_b (
      .src(pos[0].rs2), .src_used(pos[0].rs2_used & pos[0].valid), .src_fp(pos[0].rs2_fp),
      .ent_valid(pos[k].valid), .ent_we(pos[k].we), .ent_rd(pos[k].rd), .ent_fp(pos[k].fp),
      .hit(fb_hit[k])
    );
  end

  // Scan oldest to youngest so the youngest producer overwrites the choice.
  always_comb begin
    fwd_a_sel = SEL_W'(FWD_NONE);
    fwd_b_sel = SEL_W'(FWD_NONE);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (fa_hit[k]) fwd_a_sel = SEL_W'(k);
      if (fb_hit[k]) fwd_b_sel = SEL_W'(k);
    end
  end

  // Load-use: an ID source whose producer is a load still too young to bypass.
  localparam int LS_N = (LOAD_STALL > 0) ? LOAD_STALL : 1;
  logic [LS_N-1:0] ls_hit;

  if (LOAD_STALL == 0) begin : g_no_ls
    assign ls_hit = '0;
  end else begin : g_ls
    for (genvar j = 0; j < LOAD_STALL; j++) begin : g_j
      logic h1, h2;
      hazard_match u_ls1 (
        .src(id_rs1_x), .src_used(id_rs1_used), .src_fp(id_rs1_fp),
        .ent_valid(pos[j].valid), .ent_we(pos[j].we), .ent_rd(pos[j].rd), .ent_fp(pos[j].fp),
        .hit(h1)
      );
      hazard_match u_ls2 (
        .src(id_rs2_x), .src_used(id_rs2_used), .src_fp(id_rs2_fp),
        .ent_valid(pos[j].valid), .ent_we(pos[j].we), .ent_rd(pos[j].rd), .ent_fp(pos[j].fp),
        .hit(h2)
      );
      assign ls_hit[j] = pos[j].load & (h1 | h2);
    end
  end

  // Flush wins over stall: the squashed ID instruction must not hold the PC.
  assign stall_int = id_valid & ~flush & (|ls_hit);
  assign stall     = stall_int;
  assign bubble    = stall_int | flush;

  // The oldest entry's source fields only exist to complete the shift.
  logic unused_tail;
  assign unused_tail = ^{pos[FWD_DEPTH].rs1, pos[FWD_DEPTH].rs2, pos[FWD_DEPTH].rs1_used,
                         pos[FWD_DEPTH].rs2_used, pos[FWD_DEPTH].rs1_fp,
                         pos[FWD_DEPTH].rs2_fp, pos[FWD_DEPTH].load};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;
  logic        fwd_any;
  assign fwd_any = (fwd_a_sel != '0) | (fwd_b_sel != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_int && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (fwd_any && (fwd_cnt_q != '1))     fwd_cnt_q   <= fwd_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios
// followed by random instruction streams, all compared against a history-based
// model of which instructions occupied EX in recent cycles.
module tb_hazard_forward_unit;

  localparam int REG_AW     = 5;
  localparam int FWD_DEPTH  = 2;
  localparam int LOAD_STALL = 1;
  localparam int SEL_W      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_rs1_used, id_rs2_used, id_rs1_fp, id_rs2_fp;
  logic              id_rd_we, id_rd_fp, id_is_load, flush;
  logic              stall, bubble;
  logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0]       perf_stall_cnt, perf_fwd_cnt;

  hazard_forward_unit #(
    .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LOAD_STALL(LOAD_STALL), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_rd_fp(id_rd_fp), .id_is_load(id_is_load),
    .flush(flush), .stall(stall), .bubble(bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
  );

  always #5 clk = ~clk;

  // One record per cycle: the instruction that sat in EX that cycle.
  typedef struct {
    bit v; int rd; bit we; bit fp; bit ld;
    int rs1; int rs2; bit u1; bit u2; bit f1; bit f2;
  } rec_t;

  rec_t        ex_hist[$];   // [0] = in EX now, [k] = EX k cycles ago
  int          total = 0;
  int          bad   = 0;
  int unsigned cnt_s = 0, cnt_f = 0;
  bit          last_es, last_fwd, hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rec_t z;
    z = '{default: 0};
    ex_hist.delete();
    for (int i = 0; i <= FWD_DEPTH; i++) ex_hist.push_back(z);
    cnt_s = 0;
    cnt_f = 0;
  endtask

  // Does the older EX occupant p produce register (r, f)?
  function automatic bit writes(rec_t p, int r, bit f);
    return p.v && p.we && (p.rd == r) && (p.fp == f) && !(r == 0 && !f);
  endfunction

  function automatic int exp_sel(int r, bit u, bit f);
    if (!ex_hist[0].v || !u) return 0;
    for (int k = 1; k <= FWD_DEPTH; k++)
      if (writes(ex_hist[k], r, f)) return k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (!id_valid || flush) return 0;
    for (int j = 0; j < LOAD_STALL; j++)
      if (ex_hist[j].ld &&
          ((id_rs1_used && writes(ex_hist[j], int'(id_rs1), id_rs1_fp)) ||
           (id_rs2_used && writes(ex_hist[j], int'(id_rs2), id_rs2_fp))))
        return 1;
    return 0;
  endfunction

  task automatic settle(input string tag);
    bit es;
    int ea, eb;
    #3;
    es = exp_stall();
    ea = exp_sel(ex_hist[0].rs1, ex_hist[0].u1, ex_hist[0].f1);
    eb = exp_sel(ex_hist[0].rs2, ex_hist[0].u2, ex_hist[0].f2);
    chk({tag, ".stall"},  32'(stall),     32'(es));
    chk({tag, ".bubble"}, 32'(bubble),    32'(es | flush));
    chk({tag, ".sel_a"},  32'(fwd_a_sel), 32'(ea));
    chk({tag, ".sel_b"},  32'(fwd_b_sel), 32'(eb));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".pstall"}, perf_stall_cnt, cnt_s);
    chk({tag, ".pfwd"},   perf_fwd_cnt,   cnt_f);
`else
    chk({tag, ".pstall"}, perf_stall_cnt, 32'd0);
    chk({tag, ".pfwd"},   perf_fwd_cnt,   32'd0);
`endif
    last_es  = es;
    last_fwd = (ea != 0) || (eb != 0);
  endtask

  task automatic tick();
    rec_t n;
    bit   r;
    n.v  = id_valid && !last_es && !flush;
    n.rd = int'(id_rd); n.we = id_rd_we; n.fp = id_rd_fp; n.ld = id_is_load;
    n.rs1 = int'(id_rs1); n.rs2 = int'(id_rs2);
    n.u1 = id_rs1_used; n.u2 = id_rs2_used; n.f1 = id_rs1_fp; n.f2 = id_rs2_fp;
    r = rst;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      ex_hist.push_front(n);
      void'(ex_hist.pop_back());
      if (last_es)  cnt_s++;
      if (last_fwd) cnt_f++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rd, input bit we, input bit fp, input bit ld,
                       input int rs1, input bit u1, input bit f1,
                       input int rs2, input bit u2, input bit f2);
    id_valid = v; id_rd = REG_AW'(rd); id_rd_we = we; id_rd_fp = fp; id_is_load = ld;
    id_rs1 = REG_AW'(rs1); id_rs1_used = u1; id_rs1_fp = f1;
    id_rs2 = REG_AW'(rs2); id_rs2_used = u2; id_rs2_fp = f2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step(input string tag);
    settle(tag);
    tick();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < FWD_DEPTH + 1; i++) step("drain");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;

    // Reset state, with a load-dependent in ID to prove nothing stale stalls it.
    drive(1, 8, 1, 0, 0, 7, 1, 0, 7, 1, 0);
    settle("reset");
    chk("reset.stall_c", 32'(stall), 32'd0);
    chk("reset.sel_c",   32'(fwd_a_sel | fwd_b_sel), 32'd0);
    tick();
    drain();

    // add x5 ; add x6,x5,x1
    drive(1, 5, 1, 0, 0, 1, 1, 0, 2, 1, 0); step("add5");
    drive(1, 6, 1, 0, 0, 5, 1, 0, 1, 1, 0); step("add6");
    idle(); settle("fwd_mem");
    chk("fwd_mem.a", 32'(fwd_a_sel), 32'd1);
    chk("fwd_mem.b", 32'(fwd_b_sel), 32'd0);
    tick(); drain();

    // add x5 ; unrelated ; add x6,x5,x1
    drive(1, 5, 1, 0, 0, 1, 1, 0, 2, 1, 0);    step("add5b");
    drive(1, 10, 1, 0, 0, 11, 1, 0, 12, 1, 0); step("unrel");
    drive(1, 6, 1, 0, 0, 5, 1, 0, 1, 1, 0);    step("add6b");
    idle(); settle("fwd_wb");
    chk("fwd_wb.a", 32'(fwd_a_sel), 32'd2);
    tick(); drain();

    // lw x7 ; add x8,x7,x7
    drive(1, 7, 1, 0, 1, 2, 1, 0, 0, 0, 0); step("lw7");
    drive(1, 8, 1, 0, 0, 7, 1, 0, 7, 1, 0); settle("ldu1");
    chk("ldu1.stall_c",  32'(stall),  32'd1);
    chk("ldu1.bubble_c", 32'(bubble), 32'd1);
    tick();
    settle("ldu2");
    chk("ldu2.stall_c", 32'(stall), 32'd0);
    tick();
    idle(); settle("ldu_fwd");
    chk("ldu_fwd.a", 32'(fwd_a_sel), 32'd2);
    chk("ldu_fwd.b", 32'(fwd_b_sel), 32'd2);
    tick(); drain();

    // x0 never forwards; f0 does; int x3 does not feed float f3.
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); step("wx0");
    drive(1, 4, 1, 0, 0, 0, 1, 0, 0, 1, 0); step("rx0");
    idle(); settle("x0"); chk("x0.a", 32'(fwd_a_sel), 32'd0); tick(); drain();
    drive(1, 0, 1, 1, 0, 1, 1, 1, 2, 1, 1); step("wf0");
    drive(1, 4, 1, 1, 0, 0, 1, 1, 0, 0, 0); step("rf0");
    idle(); settle("f0"); chk("f0.a", 32'(fwd_a_sel), 32'd1); tick(); drain();
    drive(1, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0); step("wx3");
    drive(1, 4, 1, 1, 0, 3, 1, 1, 0, 0, 0); step("rf3");
    idle(); settle("cls"); chk("cls.a", 32'(fwd_a_sel), 32'd0); tick(); drain();

    // Two writers of x9: youngest wins.
    drive(1, 9, 1, 0, 0, 1, 1, 0, 0, 0, 0); step("w9a");
    drive(1, 9, 1, 0, 0, 2, 1, 0, 0, 0, 0); step("w9b");
    drive(1, 4, 1, 0, 0, 9, 1, 0, 9, 1, 0); step("r9");
    idle(); settle("young");
    chk("young.a", 32'(fwd_a_sel), 32'd1);
    chk("young.b", 32'(fwd_b_sel), 32'd1);
    tick(); drain();

    // Flush with a load-use condition present.
    drive(1, 7, 1, 0, 1, 2, 1, 0, 0, 0, 0); step("lw7f");
    drive(1, 8, 1, 0, 0, 7, 1, 0, 0, 0, 0); flush = 1'b1; settle("flush");
    chk("flush.stall_c",  32'(stall),  32'd0);
    chk("flush.bubble_c", 32'(bubble), 32'd1);
    tick();
    flush = 1'b0; idle(); settle("postflush");
    chk("postflush.a", 32'(fwd_a_sel), 32'd0);
    tick(); drain();

    // Reset mid-stream with three live entries and a stalling ID.
    drive(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0); step("m1");
    drive(1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0); step("m2");
    drive(1, 4, 1, 0, 1, 2, 1, 0, 1, 1, 0); step("m3");
    drive(1, 5, 1, 0, 0, 4, 1, 0, 2, 1, 0); rst = 1'b1; step("mrst");
    rst = 1'b0; settle("postrst");
    chk("postrst.stall_c", 32'(stall), 32'd0);
    chk("postrst.sel_c",   32'(fwd_a_sel | fwd_b_sel), 32'd0);
    chk("postrst.pstall_c", perf_stall_cnt, 32'd0);
    tick(); drain();

    // Three load-use stalls.
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 1, 0, 1, 2, 1, 0, 0, 0, 0); step("lwp");
      drive(1, 8, 1, 0, 0, 7, 1, 0, 0, 0, 0); step("ldp1");
      step("ldp2");
      drain();
    end
    settle("perf3");
`ifdef HAZARD_PERF_CNT_EN
    chk("perf3.c", perf_stall_cnt, 32'd3);
`else
    chk("perf3.c", perf_stall_cnt, 32'd0);
`endif
    tick();

    // Random streams over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      if (!hold)
        drive($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 9) < 8,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 3), $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 11) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      settle("rnd");
      hold = last_es && !rst;
      tick();
    end

    rst = 1'b0; flush = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
